// File: rtl/sbox_share_sched.sv
// Time-multiplexes one shared AES S-box between SubBytes (16 bytes) and SubWord (4 bytes) jobs.
// Optional RotWord on SubWord accept is enabled by defining SBOX_SHARE_SCHED_ROTWORD_EN.
module sbox_share_sched #(
  parameter int KEY_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sb_in_valid,
  output logic         sb_in_ready,
  input  logic [127:0] sb_in_data,
  output logic         sb_out_valid,
  input  logic         sb_out_ready,
  output logic [127:0] sb_out_data,
  input  logic         sw_in_valid,
  output logic         sw_in_ready,
  input  logic [31:0]  sw_in_data,
  output logic         sw_out_valid,
  input  logic         sw_out_ready,
  output logic [31:0]  sw_out_data,
  output logic [7:0]   sbox_in,
  input  logic [7:0]   sbox_out,
  output logic         busy,
  output logic         active_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN_SB = 2'd1, RUN_SW = 2'd2} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [127:0] work, sb_res;
  logic [31:0]  sw_res, sw_word;
  logic         sb_ov, sw_ov, act;
  logic         sb_elig, sw_elig, grant_sw, sb_acc, sw_acc, last_byte;

`ifdef SBOX_SHARE_SCHED_ROTWORD_EN
  assign sw_word = {sw_in_data[23:0], sw_in_data[31:24]};
`else
  assign sw_word = sw_in_data;
`endif

  always_comb begin
    sb_elig   = sb_in_valid & ~sb_ov;
    sw_elig   = sw_in_valid & ~sw_ov;
    // On a tie SW wins under strict priority, or when SB held the last grant.
    grant_sw  = sw_elig & (~sb_elig | (KEY_PRIO != 0) | ~act);
    sb_acc    = (state == IDLE) & sb_elig & ~grant_sw;
    sw_acc    = (state == IDLE) & grant_sw;
    last_byte = ((state == RUN_SB) & (cnt == 4'd15)) |
                ((state == RUN_SW) & (cnt == 4'd3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           if (sw_acc) state_nxt = RUN_SW;
                      else if (sb_acc) state_nxt = RUN_SB;
      RUN_SB, RUN_SW: if (last_byte) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    sb_in_ready = sb_acc;
    sw_in_ready = sw_acc;
    sbox_in     = 8'h00;
    if (state != IDLE) sbox_in = work[{cnt, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      work   <= '0;
      sb_res <= '0;
      sw_res <= '0;
      sb_ov  <= 1'b0;
      sw_ov  <= 1'b0;
      act    <= 1'b0;
    end else begin
      if (sb_acc || sw_acc || last_byte) cnt <= '0;
      else if (state != IDLE)            cnt <= cnt + 4'd1;

      if (sb_acc) begin
        work <= sb_in_data;
        act  <= 1'b0;
      end else if (sw_acc) begin
        work <= {96'd0, sw_word};
        act  <= 1'b1;
      end

      // Result bytes land in place, so out_data is frozen once the job ends.
      if (state == RUN_SB) sb_res[{cnt, 3'b000} +: 8] <= sbox_out;
      if (state == RUN_SW) sw_res[{cnt[1:0], 3'b000} +: 8] <= sbox_out;

      if ((state == RUN_SB) && last_byte) sb_ov <= 1'b1;
      else if (sb_out_ready)              sb_ov <= 1'b0;

      if ((state == RUN_SW) && last_byte) sw_ov <= 1'b1;
      else if (sw_out_ready)              sw_ov <= 1'b0;
    end
  end

  assign sb_out_valid = sb_ov;
  assign sw_out_valid = sw_ov;
  assign sb_out_data  = sb_res;
  assign sw_out_data  = sw_res;
  assign active_id    = act;

endmodule

// File: tb/tb_sbox_share_sched.sv
// Bench for sbox_share_sched: dut0 round-robin, dut1 key priority, S-box modelled in GF(2^8).
module tb_sbox_share_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         sb_in_valid [2];
  logic         sb_in_ready [2];
  logic [127:0] sb_in_data  [2];
  logic         sb_out_valid[2];
  logic         sb_out_ready[2];
  logic [127:0] sb_out_data [2];
  logic         sw_in_valid [2];
  logic         sw_in_ready [2];
  logic [31:0]  sw_in_data  [2];
  logic         sw_out_valid[2];
  logic         sw_out_ready[2];
  logic [31:0]  sw_out_data [2];
  logic [7:0]   sbox_in     [2];
  logic [7:0]   sbox_out    [2];
  logic         busy        [2];
  logic         active_id   [2];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the AES affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] s, r, b;
    s = x; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_f(x[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] sw_work(input logic [31:0] w);
`ifdef SBOX_SHARE_SCHED_ROTWORD_EN
    return {w[23:0], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] x, r;
    x = sw_work(w);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_f(x[8*i +: 8]);
    return r;
  endfunction

  assign sbox_out[0] = sbox_f(sbox_in[0]);
  assign sbox_out[1] = sbox_f(sbox_in[1]);

  sbox_share_sched #(.KEY_PRIO(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .sb_in_valid(sb_in_valid[0]), .sb_in_ready(sb_in_ready[0]), .sb_in_data(sb_in_data[0]),
    .sb_out_valid(sb_out_valid[0]), .sb_out_ready(sb_out_ready[0]), .sb_out_data(sb_out_data[0]),
    .sw_in_valid(sw_in_valid[0]), .sw_in_ready(sw_in_ready[0]), .sw_in_data(sw_in_data[0]),
    .sw_out_valid(sw_out_valid[0]), .sw_out_ready(sw_out_ready[0]), .sw_out_data(sw_out_data[0]),
    .sbox_in(sbox_in[0]), .sbox_out(sbox_out[0]), .busy(busy[0]), .active_id(active_id[0])
  );

  sbox_share_sched #(.KEY_PRIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .sb_in_valid(sb_in_valid[1]), .sb_in_ready(sb_in_ready[1]), .sb_in_data(sb_in_data[1]),
    .sb_out_valid(sb_out_valid[1]), .sb_out_ready(sb_out_ready[1]), .sb_out_data(sb_out_data[1]),
    .sw_in_valid(sw_in_valid[1]), .sw_in_ready(sw_in_ready[1]), .sw_in_data(sw_in_data[1]),
    .sw_out_valid(sw_out_valid[1]), .sw_out_ready(sw_out_ready[1]), .sw_out_data(sw_out_data[1]),
    .sbox_in(sbox_in[1]), .sbox_out(sbox_out[1]), .busy(busy[1]), .active_id(active_id[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int d);
    sb_in_valid[d] = 1'b0; sb_in_data[d] = '0; sb_out_ready[d] = 1'b0;
    sw_in_valid[d] = 1'b0; sw_in_data[d] = '0; sw_out_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    logic [13:0] ctl;
    idle_inputs(0);
    idle_inputs(1);
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      ctl = {busy[d], active_id[d], sb_out_valid[d], sw_out_valid[d],
             sb_in_ready[d], sw_in_ready[d], sbox_in[d]};
      checks++;
      if (ctl !== 14'h0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d got %h exp 0", d, ctl);
      end
      checks++;
      if ({sb_out_data[d], sw_out_data[d]} !== 160'h0) begin
        errors++;
        $display("FAIL reset_data dut%0d got %h/%h exp 0", d, sb_out_data[d], sw_out_data[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sb_job(input int d, input logic [127:0] data);
    logic [127:0] exp;
    exp = sub_bytes(data);
    sb_in_data[d] = data; sb_in_valid[d] = 1'b1; sb_out_ready[d] = 1'b0;
    #1;
    checks++;
    if ({sb_in_ready[d], busy[d], sb_out_valid[d]} !== 3'b100) begin
      errors++;
      $display("FAIL sb_accept dut%0d got rdy/busy/ov=%b exp 100",
               d, {sb_in_ready[d], busy[d], sb_out_valid[d]});
    end
    tick();
    sb_in_valid[d] = 1'b0;
    sb_in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({busy[d], sb_out_valid[d], sb_in_ready[d], sbox_in[d]} !== {3'b100, data[8*k +: 8]}) begin
        errors++;
        $display("FAIL sb_run dut%0d k=%0d got busy/ov/rdy=%b sbox_in=%h exp 100 %h", d, k,
                 {busy[d], sb_out_valid[d], sb_in_ready[d]}, sbox_in[d], data[8*k +: 8]);
      end
      tick();
    end
    checks++;
    if ({sb_out_valid[d], busy[d], sbox_in[d]} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL sb_done dut%0d got ov/busy=%b sbox_in=%h exp 10 00",
               d, {sb_out_valid[d], busy[d]}, sbox_in[d]);
    end
    checks++;
    if (sb_out_data[d] !== exp) begin
      errors++;
      $display("FAIL sb_data dut%0d got %h exp %h", d, sb_out_data[d], exp);
    end
    sb_out_ready[d] = 1'b1;
    tick();
    sb_out_ready[d] = 1'b0;
    checks++;
    if ({sb_out_valid[d], sb_out_data[d]} !== {1'b0, exp}) begin
      errors++;
      $display("FAIL sb_consume dut%0d got ov=%b %h exp 0 %h", d, sb_out_valid[d], sb_out_data[d], exp);
    end
  endtask

  task automatic test_sw_job(input int d, input logic [31:0] data);
    logic [31:0] exp, w;
    exp = sub_word(data);
    w   = sw_work(data);
    sw_in_data[d] = data; sw_in_valid[d] = 1'b1; sw_out_ready[d] = 1'b0;
    #1;
    checks++;
    if ({sw_in_ready[d], busy[d], sw_out_valid[d]} !== 3'b100) begin
      errors++;
      $display("FAIL sw_accept dut%0d got rdy/busy/ov=%b exp 100",
               d, {sw_in_ready[d], busy[d], sw_out_valid[d]});
    end
    tick();
    sw_in_valid[d] = 1'b0;
    sw_in_data[d]  = $urandom;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({busy[d], sw_out_valid[d], active_id[d], sbox_in[d]} !== {3'b101, w[8*k +: 8]}) begin
        errors++;
        $display("FAIL sw_run dut%0d k=%0d got busy/ov/id=%b sbox_in=%h exp 101 %h", d, k,
                 {busy[d], sw_out_valid[d], active_id[d]}, sbox_in[d], w[8*k +: 8]);
      end
      tick();
    end
    checks++;
    if ({sw_out_valid[d], busy[d], sw_out_data[d]} !== {2'b10, exp}) begin
      errors++;
      $display("FAIL sw_done dut%0d got ov/busy=%b %h exp 10 %h",
               d, {sw_out_valid[d], busy[d]}, sw_out_data[d], exp);
    end
    sw_out_ready[d] = 1'b1;
    tick();
    sw_out_ready[d] = 1'b0;
    checks++;
    if ({sw_out_valid[d], sw_out_data[d]} !== {1'b0, exp}) begin
      errors++;
      $display("FAIL sw_consume dut%0d got ov=%b %h exp 0 %h", d, sw_out_valid[d], sw_out_data[d], exp);
    end
  endtask

  task automatic test_known_vectors;
    logic [127:0] exp53;
    logic [31:0]  expw;
    exp53 = {{15{8'h63}}, 8'hED};
`ifdef SBOX_SHARE_SCHED_ROTWORD_EN
    expw = 32'h8A84EB01;
`else
    expw = 32'h018A84EB;
`endif
    test_sb_job(0, 128'h0);
    checks++;
    if (sb_out_data[0] !== {16{8'h63}}) begin
      errors++;
      $display("FAIL sb_zero_vec got %h exp 63..63", sb_out_data[0]);
    end
    test_sb_job(0, 128'h53);
    checks++;
    if (sb_out_data[0] !== exp53) begin
      errors++;
      $display("FAIL sb_53_vec got %h exp %h", sb_out_data[0], exp53);
    end
    test_sw_job(0, 32'h09CF4F3C);
    checks++;
    if (sw_out_data[0] !== expw) begin
      errors++;
      $display("FAIL sw_vec got %h exp %h", sw_out_data[0], expw);
    end
  endtask

  task automatic test_random_jobs;
    for (int i = 0; i < 6; i++) begin
      test_sb_job(i % 2, {$urandom, $urandom, $urandom, $urandom});
      test_sw_job(i % 2, $urandom);
    end
  endtask

  // Transaction-level model: job lengths, eligibility and grant rules, results via sub_bytes/sub_word.
  // mode 0: both always requesting, results drained; mode 1: SW result held until cycle 40; mode 2: random.
  task automatic test_traffic(input int d, input int mode, input int ncyc);
    int           rem, ngrant;
    bit           m_act, m_sb_ov, m_sw_ov, g_sb, g_sw, e_sb, e_sw;
    logic [127:0] m_sb_exp;
    logic [31:0]  m_sw_exp;
    logic [5:0]   exp_ctl, obs_ctl;
    bit           grants[$];
    rem = 0; m_act = 1'b0; m_sb_ov = 1'b0; m_sw_ov = 1'b0;
    m_sb_exp = '0; m_sw_exp = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      case (mode)
        0: begin
          sb_in_valid[d] = 1'b1; sw_in_valid[d] = 1'b1;
          sb_out_ready[d] = 1'b1; sw_out_ready[d] = 1'b1;
        end
        1: begin
          sb_in_valid[d] = 1'b1; sw_in_valid[d] = 1'b1;
          sb_out_ready[d] = 1'b1; sw_out_ready[d] = (c >= 40);
        end
        default: begin
          sb_in_valid[d]  = ($urandom_range(0, 3) != 0);
          sw_in_valid[d]  = ($urandom_range(0, 3) != 0);
          sb_out_ready[d] = $urandom_range(0, 1);
          sw_out_ready[d] = $urandom_range(0, 1);
        end
      endcase
      sb_in_data[d] = {$urandom, $urandom, $urandom, $urandom};
      sw_in_data[d] = $urandom;
      #1;
      e_sb = sb_in_valid[d] && !m_sb_ov;
      e_sw = sw_in_valid[d] && !m_sw_ov;
      g_sb = 1'b0; g_sw = 1'b0;
      if (rem == 0) begin
        if (e_sb && e_sw) begin
          if (d == 1 || m_act == 1'b0) g_sw = 1'b1;
          else                         g_sb = 1'b1;
        end else begin
          g_sb = e_sb;
          g_sw = e_sw;
        end
      end
      exp_ctl = {g_sb, g_sw, rem != 0, m_sb_ov, m_sw_ov, m_act};
      obs_ctl = {sb_in_ready[d], sw_in_ready[d], busy[d], sb_out_valid[d], sw_out_valid[d], active_id[d]};
      checks++;
      if (obs_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL traffic_ctrl dut%0d m%0d c=%0d got %b exp %b (rdy_sb rdy_sw busy ov_sb ov_sw id)",
                 d, mode, c, obs_ctl, exp_ctl);
      end
      if (m_sb_ov) begin
        checks++;
        if (sb_out_data[d] !== m_sb_exp) begin
          errors++;
          $display("FAIL traffic_sb_data dut%0d c=%0d got %h exp %h", d, c, sb_out_data[d], m_sb_exp);
        end
      end
      if (m_sw_ov) begin
        checks++;
        if (sw_out_data[d] !== m_sw_exp) begin
          errors++;
          $display("FAIL traffic_sw_data dut%0d c=%0d got %h exp %h", d, c, sw_out_data[d], m_sw_exp);
        end
      end
      if (sb_out_ready[d]) m_sb_ov = 1'b0;
      if (sw_out_ready[d]) m_sw_ov = 1'b0;
      if (g_sb) begin
        rem = 16; m_act = 1'b0; m_sb_exp = sub_bytes(sb_in_data[d]); grants.push_back(1'b0);
      end else if (g_sw) begin
        rem = 4; m_act = 1'b1; m_sw_exp = sub_word(sw_in_data[d]); grants.push_back(1'b1);
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          if (m_act) m_sw_ov = 1'b1;
          else       m_sb_ov = 1'b1;
        end
      end
      tick();
    end
    ngrant = grants.size();
    if (mode == 0) begin
      checks++;
      if (ngrant < 4 || {grants[0], grants[1], grants[2], grants[3]} !== 4'b1010) begin
        errors++;
        $display("FAIL rr_order dut%0d got %0d grants first=%b exp 1010", d, ngrant,
                 (ngrant >= 4) ? {grants[0], grants[1], grants[2], grants[3]} : 4'b0000);
      end
    end
    if (mode == 1) begin
      checks++;
      if (ngrant < 4 || {grants[0], grants[1], grants[2], grants[3]} !== 4'b1001) begin
        errors++;
        $display("FAIL prio_order dut%0d got %0d grants first=%b exp 1001", d, ngrant,
                 (ngrant >= 4) ? {grants[0], grants[1], grants[2], grants[3]} : 4'b0000);
      end
    end
    sb_in_valid[d] = 1'b0; sw_in_valid[d] = 1'b0;
    sb_out_ready[d] = 1'b1; sw_out_ready[d] = 1'b1;
    repeat (20) tick();
    idle_inputs(d);
  endtask

  task automatic test_reset_mid_job;
    logic [127:0] data;
    logic [10:0]  ctl;
    data = {$urandom, $urandom, $urandom, $urandom} | {16{8'h01}};
    sb_in_data[0] = data; sb_in_valid[0] = 1'b1; sb_out_ready[0] = 1'b0;
    tick();
    sb_in_valid[0] = 1'b0;
    repeat (7) tick();
    checks++;
    if ({busy[0], sbox_in[0]} !== {1'b1, data[63:56]}) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b sbox_in=%h exp 1 %h", busy[0], sbox_in[0], data[63:56]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    ctl = {busy[0], active_id[0], sb_out_valid[0], sbox_in[0]};
    checks++;
    if (ctl !== 11'h0) begin
      errors++;
      $display("FAIL midrst_ctrl got %h exp 0", ctl);
    end
    checks++;
    if (sb_out_data[0] !== 128'h0) begin
      errors++;
      $display("FAIL midrst_data got %h exp 0", sb_out_data[0]);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      checks++;
      if ({sb_out_valid[0], busy[0]} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_ghost c=%0d got ov/busy=%b exp 00", c, {sb_out_valid[0], busy[0]});
      end
      tick();
    end
    test_sb_job(0, {$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_jobs();
    test_traffic(0, 0, 80);
    test_traffic(1, 1, 80);
    test_traffic(0, 2, 600);
    test_traffic(1, 2, 600);
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
Time-multiplexes one shared combinational AES S-box (8-bit in, 8-bit out) between two requesters.
- SubBytes datapath: 128-bit state, 16 bytes.
- Key-expansion SubWord: 32-bit word, 4 bytes.
One byte is substituted per cycle. Each requester has a valid/ready request port and a valid/ready result port. Sits between the round datapath, the key scheduler and the single S-box instance in the AES core.

Parameters:
- KEY_PRIO, 0, 1 = SubWord has strict priority over SubBytes; 0 = round-robin between requesters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- sb_in_valid  input  1  SubBytes job request.
- sb_in_ready  output  1  SubBytes job accepted this cycle when high with sb_in_valid.
- sb_in_data  input  128  state to substitute; byte k = bits [8k+7:8k].
- sb_out_valid  output  1  SubBytes result available.
- sb_out_ready  input  1  SubBytes result consumed.
- sb_out_data  output  128  substituted state.
- sw_in_valid  input  1  SubWord job request.
- sw_in_ready  output  1  SubWord job accepted.
- sw_in_data  input  32  word to substitute.
- sw_out_valid  output  1  SubWord result available.
- sw_out_ready  input  1  SubWord result consumed.
- sw_out_data  output  32  substituted word.
- sbox_in  output  8  byte driven to the shared S-box.
- sbox_out  input  8  S-box result, combinational from sbox_in in the same cycle.
- busy  output  1  FSM not in IDLE.
- active_id  output  1  0 = SubBytes job running or last run; 1 = SubWord.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; byte counter = 0.
  - sb_out_valid = sw_out_valid = 0; sb_out_data = 0; sw_out_data = 0.
  - busy = 0; active_id = 0; round-robin "last granted" = SubBytes.
  - Reset mid-job discards the partial result; no out_valid is raised for it.
- FSM states and transitions:
  - IDLE: arbitrate as below. Accepting SB goes to RUN_SB; accepting SW goes to RUN_SW.
  - RUN_SB: counter runs 0..15, then returns to IDLE.
  - RUN_SW: counter runs 0..3, then returns to IDLE.
- Eligibility: a requester is eligible when in_valid=1 and its out_valid=0. No new job is accepted while that requester's previous result is unconsumed.
- Arbitration, IDLE only, combinational:
  - Only one requester eligible: it is granted.
  - Both eligible, KEY_PRIO=1: SW is granted.
  - Both eligible, KEY_PRIO=0: the requester not granted last is granted.
  - in_ready = IDLE & eligible & granted. At most one accept per cycle. in_ready is always 0 outside IDLE.
  - On accept, the input data is latched into an internal working register, the counter is cleared, and active_id is updated.
- Running:
  - Cycle k: sbox_in = working byte k; sbox_out is written to result byte k at the clock edge.
  - Byte 0 is processed first.
  - In IDLE, sbox_in = 8'h00.
- Latency and completion:
  - Accept at edge E0; result bytes are written at edges E1..E16 (SB) or E1..E4 (SW).
  - At the final edge, out_valid goes to 1, FSM goes to IDLE and busy goes to 0.
  - out_valid is therefore first visible 16 (SB) or 4 (SW) cycles after accept.
- Result hold:
  - out_data is stable while out_valid=1.
  - out_valid & out_ready clears out_valid at the next edge. out_data keeps its value.
  - The freed requester becomes eligible the following cycle. There is no same-cycle consume+accept.
- Back-to-back: a minimum of one IDLE cycle separates jobs. The other requester may be accepted in the IDLE cycle that immediately follows a completion.
- out_ready while out_valid=0 is ignored. in_valid is never required to stay high once in_ready=1 has been seen.

Optional Feature:
- Macro: SBOX_SHARE_SCHED_ROTWORD_EN.
- When defined: the SubWord job applies RotWord at accept. The working word = {sw_in_data[23:0], sw_in_data[31:24]}, so sw_out_data = SubWord(RotWord(w)).
- When undefined: the word is latched unrotated, giving sw_out_data = SubWord(w).
- SubBytes jobs are unaffected either way.

Test Plan:
- Reset then SB job, sb_in_data=128'h0, sb_out_ready=1 → sb_in_ready=1 on the request cycle; sb_out_valid rises 16 cycles later; sb_out_data=128'h6363…63; busy high exactly 16 cycles.
- SB job with byte0=8'h53 and other bytes 0 → sb_out_data byte0=8'hED, other bytes 8'h63; sbox_in shows 8'h53 in the first RUN cycle.
- SW job, sw_in_data=32'h09CF4F3C:
  - Without macro → sw_out_data=32'h018A84EB after 4 cycles.
  - With SBOX_SHARE_SCHED_ROTWORD_EN → 32'h8A84EB01.
- KEY_PRIO=0, both valid continuously, both out_ready=1 → grants alternate: SW first after reset, then SB, SW, SB. One IDLE cycle between jobs; active_id toggles.
- KEY_PRIO=1, both valid continuously with sw_out_ready=0 → SW granted first. The second SW request is blocked (sw_in_ready=0 while sw_out_valid=1). SB is granted next. sw_out_data stays stable until sw_out_ready=1.
- Assert rst_n=0 at RUN_SB count 7 → all outputs return to reset values immediately. After release, no sb_out_valid appears; a new SB job completes normally.
